tdc_sweep_ctrl: RTL
===================

TDC_SWEEP_CTRL -- requirements
Module: tdc_sweep_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port cfg_start, input, 1 bit: one-cycle sweep request; ignored while busy=1.
REQ-004 SHALL have port cfg_abort, input, 1 bit: terminate any sweep.
REQ-005 SHALL have port cfg_code_lo, input, 5 bits: first delay code of the sweep.
REQ-006 SHALL have port cfg_code_hi, input, 5 bits: last delay code of the sweep.
REQ-007 SHALL have port cfg_reps, input, 4 bits: samples per code, minus 1.
REQ-008 SHALL have port cfg_settle, input, 4 bits: settle cycles per sample, minus 1.
REQ-009 SHALL have ports cfg_trim_start and cfg_trim_stop, inputs, 4 bits each: input-stage trim codes.
REQ-010 SHALL have port term_in, input, 8 bits: asynchronous thermometer taps from the vernier line.
REQ-011 SHALL have port dly_en, output, 5 bits: stop-path variable-delay select.
REQ-012 SHALL have ports trim_start and trim_stop, outputs, 4 bits each: registered trim codes.
REQ-013 SHALL have port start_en, output, 1 bit: start input-stage enable.
REQ-014 SHALL have port trig, output, 1 bit: measurement edge into the input stages.
REQ-015 SHALL have ports res_valid (output, 1 bit) and res_ready (input, 1 bit): result handshake.
REQ-016 SHALL have ports res_code (5 bits), res_sum (8 bits) and res_bubble (1 bit), all outputs: result payload.
REQ-017 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, pulse), plus cfg_err (output, 1 bit).

Function
REQ-018 SHALL pass term_in through a 2-flop synchronizer before any use.
REQ-019 SHALL latch all cfg_* values when cfg_start is accepted and hold them constant for the sweep.
REQ-020 SHALL use FSM states IDLE, SETUP, FIRE, WAIT, SAMPLE, EMIT, DONE.
REQ-021 IDLE->SETUP on accepted cfg_start; on entry load code=cfg_code_lo, rep=0, sum=0, bubble=0, and set busy=1.
REQ-022 SETUP SHALL drive dly_en=code, start_en=1 and trig=0 for cfg_settle+1 cycles, then go to FIRE.
REQ-023 FIRE SHALL drive trig=1 for exactly 1 cycle, then go to WAIT.
REQ-024 WAIT SHALL hold trig=0 for 3 cycles (synchronizer plus margin), then go to SAMPLE.
REQ-025 SAMPLE (1 cycle) SHALL add popcount(synced term), range 0-8, to sum.
REQ-026 SAMPLE SHALL set bubble sticky if synced term is not of the form 2^k-1.
REQ-027 SAMPLE SHALL go to SETUP with rep+1 if rep<cfg_reps, else to EMIT.
REQ-028 EMIT SHALL hold res_valid=1 with res_code=code, res_sum=sum and res_bubble=bubble stable until res_ready=1.
REQ-029 On an EMIT handshake: if code==cfg_code_hi go to DONE; else code+1, rep=0, sum=0, bubble=0, go to SETUP.
REQ-030 sum width SHALL be 8 bits; the maximum 16x8=128 SHALL not overflow.
REQ-031 If cfg_code_hi<cfg_code_lo at start, SHALL set cfg_err=1 (cleared on next accepted start) and measure cfg_code_lo only.
REQ-032 DONE SHALL pulse done=1 for 1 cycle, then go to IDLE with busy=0.
REQ-033 Latency: first res_valid SHALL assert cfg_settle+7 cycles after the cfg_start cycle.
REQ-034 cfg_abort SHALL move any state to IDLE next cycle with trig=0, start_en=0, res_valid=0, busy=0 and no done pulse; abort takes priority over a same-cycle handshake or start.
REQ-035 In IDLE, outputs SHALL be trig=0 and start_en=0, with dly_en, trim_start and trim_stop holding their last values.

Reset
REQ-036 On rst_n=0, all outputs SHALL go to 0, the FSM to IDLE and the synchronizer to 0, asynchronously; reset mid-sweep discards partial results.

Structure
REQ-037 Package tdc_ctrl_pkg SHALL hold the state enum, CODE_W=5, TERM_W=8, SUM_W=8, TRIM_W=4, SYNC_STAGES=2 and WAIT_CYC=3.
REQ-038 Popcount and bubble detection SHALL live in sub-module tdc_therm_decode, which is combinational.

Verification
REQ-039 lo=hi=3, reps=0, settle=0, term=8'h0F -> res_valid at cycle 7, res_code=3, res_sum=4, res_bubble=0, done one cycle after the handshake.
REQ-040 lo=0, hi=31, reps=15, term=8'hFF, res_ready=1 -> 32 results with codes 0-31 in order, each res_sum=128.
REQ-041 term=8'h05 during one sample of four -> res_bubble=1 for that code only; sum includes popcount 2.
REQ-042 res_ready=0 for 10 cycles in EMIT -> payload stable, no trig pulses, and resumes after ready.
REQ-043 lo=5, hi=2 -> cfg_err=1 and a single result with code 5.
REQ-044 cfg_abort in WAIT, and separately rst_n low in EMIT -> IDLE with all outputs quiet and no done pulse; cfg_start during busy is ignored.

Source files
------------

// File: rtl/tdc_sweep_ctrl_pkg.sv
// Shared widths, timing constants and FSM state encoding for the TDC sweep controller.
// Combinational only (no state); imported by every file of the block.
package tdc_ctrl_pkg;
  localparam int CODE_W      = 5;
  localparam int TERM_W      = 8;
  localparam int SUM_W       = 8;
  localparam int TRIM_W      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int WAIT_CYC    = 3;
  localparam int CNT_W       = 4;
  localparam int POP_W       = $clog2(TERM_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    WAIT,
    SAMPLE,
    EMIT,
    DONE
  } state_e;
endpackage

// File: rtl/tdc_sweep_ctrl_if.sv
// Per-code result stream: the controller drives it (master) and the consumer drains it (slave).
// Valid/ready; the payload holds steady while valid is high and ready is low.
interface tdc_sweep_ctrl_if;
  import tdc_ctrl_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [CODE_W-1:0] res_code;
  logic [SUM_W-1:0]  res_sum;
  logic              res_bubble;

  modport master (output res_valid, output res_code, output res_sum, output res_bubble,
                  input  res_ready);
  modport slave  (input  res_valid, input  res_code, input  res_sum, input  res_bubble,
                  output res_ready);
endinterface

// File: rtl/tdc_sweep_ctrl_therm_decode.sv
// Thermometer decode: popcount of the tap word, and a flag for any word that is not 2^k-1.
// Zero latency (pure combinational), no flow control.
module tdc_therm_decode
  import tdc_ctrl_pkg::*;
(
  input  logic [TERM_W-1:0] term_i,
  output logic [POP_W-1:0]  pop_o,
  output logic              bubble_o
);

  always_comb begin
    pop_o = '0;
    for (int i = 0; i < TERM_W; i++) begin
      pop_o = pop_o + POP_W'(term_i[i]);
    end
    // A clean thermometer word t = 2^k-1 has no bit in common with t+1.
    bubble_o = |(term_i & (term_i + TERM_W'(1)));
  end

endmodule

// File: rtl/tdc_sweep_ctrl.sv
// Sweeps the stop-path delay code from lo to hi, firing reps+1 measurements per code and emitting one summed result per code.
// First result cfg_settle+7 cycles after the start; the sweep stalls in EMIT while res_ready is low.
module tdc_sweep_ctrl
  import tdc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [CODE_W-1:0] cfg_code_lo,
  input  logic [CODE_W-1:0] cfg_code_hi,
  input  logic [CNT_W-1:0]  cfg_reps,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic [TRIM_W-1:0] cfg_trim_start,
  input  logic [TRIM_W-1:0] cfg_trim_stop,
  input  logic [TERM_W-1:0] term_in,
  output logic [CODE_W-1:0] dly_en,
  output logic [TRIM_W-1:0] trim_start,
  output logic [TRIM_W-1:0] trim_stop,
  output logic              start_en,
  output logic              trig,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  tdc_sweep_ctrl_if.master  res
);

  state_e                             state_q, state_d;
  logic [SYNC_STAGES-1:0][TERM_W-1:0] sync_q;
  logic [CODE_W-1:0]                  code_q, code_d, hi_q, hi_d, dly_q, dly_d;
  logic [CNT_W-1:0]                   reps_q, reps_d, settle_q, settle_d;
  logic [CNT_W-1:0]                   rep_q, rep_d, cnt_q, cnt_d;
  logic [SUM_W-1:0]                   sum_q, sum_d;
  logic                               bubble_q, bubble_d, err_q, err_d;
  logic [TRIM_W-1:0]                  trs_q, trs_d, trp_q, trp_d;
  logic [POP_W-1:0]                   pop;
  logic                               pop_bubble;

  tdc_therm_decode u_decode (
    .term_i   (sync_q[SYNC_STAGES-1]),
    .pop_o    (pop),
    .bubble_o (pop_bubble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      code_q   <= '0;
      hi_q     <= '0;
      dly_q    <= '0;
      reps_q   <= '0;
      settle_q <= '0;
      rep_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      bubble_q <= 1'b0;
      err_q    <= 1'b0;
      trs_q    <= '0;
      trp_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], term_in};
      code_q   <= code_d;
      hi_q     <= hi_d;
      dly_q    <= dly_d;
      reps_q   <= reps_d;
      settle_q <= settle_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      bubble_q <= bubble_d;
      err_q    <= err_d;
      trs_q    <= trs_d;
      trp_q    <= trp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    hi_d     = hi_q;
    reps_d   = reps_q;
    settle_d = settle_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    bubble_d = bubble_q;
    err_d    = err_q;
    trs_d    = trs_q;
    trp_d    = trp_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d  = SETUP;
          err_d    = (cfg_code_hi < cfg_code_lo);
          code_d   = cfg_code_lo;
          // An inverted range collapses to a single-code sweep of lo.
          hi_d     = (cfg_code_hi < cfg_code_lo) ? cfg_code_lo : cfg_code_hi;
          reps_d   = cfg_reps;
          settle_d = cfg_settle;
          trs_d    = cfg_trim_start;
          trp_d    = cfg_trim_stop;
          rep_d    = '0;
          cnt_d    = '0;
          sum_d    = '0;
          bubble_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == settle_q) begin
          state_d = FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        sum_d    = sum_q + SUM_W'(pop);
        bubble_d = bubble_q | pop_bubble;
        if (rep_q < reps_q) begin
          rep_d   = rep_q + 1'b1;
          state_d = SETUP;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (res.res_ready) begin
          if (code_q == hi_q) begin
            state_d = DONE;
          end else begin
            code_d   = code_q + 1'b1;
            rep_d    = '0;
            sum_d    = '0;
            bubble_d = 1'b0;
            state_d  = SETUP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cfg_abort) begin
      state_d = IDLE;
    end

    dly_d = (state_d == SETUP) ? code_d : dly_q;
  end

  // Input stage stays armed from settle through the sample so the fired edge is captured.
  assign start_en       = (state_q == SETUP) || (state_q == FIRE) ||
                          (state_q == WAIT)  || (state_q == SAMPLE);
  assign trig           = (state_q == FIRE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign cfg_err        = err_q;
  assign dly_en         = dly_q;
  assign trim_start     = trs_q;
  assign trim_stop      = trp_q;
  assign res.res_valid  = (state_q == EMIT);
  assign res.res_code   = code_q;
  assign res.res_sum    = sum_q;
  assign res.res_bubble = bubble_q;

endmodule
